// File: rtl/fm_radio_pkg.sv
// Shared FM radio definitions: default sample width and the FIFO occupancy state.
package fm_radio_pkg;

    localparam int DATA_SIZE_DEFAULT = 32;

    typedef enum logic {
        EMPTY_ST  = 1'b0,
        ACTIVE_ST = 1'b1
    } occ_state_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Sample storage: one registered write port and one asynchronous read port.
module sample_fifo_mem #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_SIZE  = $clog2(FIFO_DEPTH)
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];

    // Contents are never reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// First-word-fall-through sample FIFO with sticky overflow/underflow flags.
module sample_fifo
    import fm_radio_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [DATA_SIZE-1:0]          din,
    output logic                          full,
    input  logic                          rd_en,
    output logic [DATA_SIZE-1:0]          dout,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] ONE_ENTRY = 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    occ_state_t  state;
    occ_state_t  state_next;
    logic        wr_accept;
    logic        rd_accept;

    // The extra pointer MSB separates a full ring from an empty one.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (state == EMPTY_ST);
    assign count = wr_ptr - rd_ptr;

    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            state     <= EMPTY_ST;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE_ENTRY;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ONE_ENTRY;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY_ST: begin
                if (wr_accept) begin
                    state_next = ACTIVE_ST;
                end
            end
            ACTIVE_ST: begin
                if (rd_accept && !wr_accept && (count == ONE_ENTRY)) begin
                    state_next = EMPTY_ST;
                end
            end
            default: state_next = EMPTY_ST;
        endcase
    end

    sample_fifo_mem #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_SIZE  (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (wr_accept && reset),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_sample_fifo.sv
// Directed self-checking bench for sample_fifo with hand-computed expectations.
module tb_sample_fifo;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [31:0] din;
    logic        full;
    logic        rd_en;
    logic [31:0] dout;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    int assertCount = 0;
    int failCount   = 0;

    sample_fifo #(
        .DATA_SIZE  (32),
        .FIFO_DEPTH (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .din       (din),
        .full      (full),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of requests, then settle just after the rising edge.
    task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #2;
        checkOutput("reset_empty",     32'(empty),     32'd1);
        checkOutput("reset_full",      32'(full),      32'd0);
        checkOutput("reset_count",     32'(count),     32'd0);
        checkOutput("reset_overflow",  32'(overflow),  32'd0);
        checkOutput("reset_underflow", 32'(underflow), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // One-cycle write-to-read latency.
        applyStimulus(1'b1, 32'h0000_00B2, 1'b0);
        checkOutput("lat_empty", 32'(empty), 32'd0);
        checkOutput("lat_dout",  dout,       32'h0000_00B2);
        checkOutput("lat_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("lat_drain_empty", 32'(empty),     32'd1);
        checkOutput("lat_underflow",   32'(underflow), 32'd0);

        // Fill to the brim, then attempt one more write.
        for (int i = 1; i <= 16; i++) begin
            checkOutput("fill_not_full", 32'(full), 32'd0);
            applyStimulus(1'b1, 32'(i), 1'b0);
            checkOutput("fill_count", 32'(count), 32'(i));
        end
        checkOutput("fill_full",   32'(full),  32'd1);
        checkOutput("fill_dout",   dout,       32'h0000_0001);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("ovf_flag",  32'(overflow), 32'd1);
        checkOutput("ovf_count", 32'(count),    32'd16);
        checkOutput("ovf_dout",  dout,          32'h0000_0001);

        // Drain in order; the dropped write must not appear.
        for (int i = 1; i <= 16; i++) begin
            checkOutput("drain_dout", dout, 32'(i));
            applyStimulus(1'b0, 32'h0, 1'b1);
            checkOutput("drain_count", 32'(count), 32'(16 - i));
        end
        checkOutput("drain_empty",  32'(empty),     32'd1);
        checkOutput("drain_uf_pre", 32'(underflow), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("udf_flag",     32'(underflow), 32'd1);
        checkOutput("udf_count",    32'(count),     32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("udf_sticky",   32'(underflow), 32'd1);
        checkOutput("ovf_sticky",   32'(overflow),  32'd1);

        pulseReset();
        checkOutput("rst2_overflow",  32'(overflow),  32'd0);
        checkOutput("rst2_underflow", 32'(underflow), 32'd0);

        // Simultaneous requests while empty: write taken, read ignored.
        applyStimulus(1'b1, 32'h0000_00A0, 1'b1);
        checkOutput("both_empty_count", 32'(count),     32'd1);
        checkOutput("both_empty_udf",   32'(underflow), 32'd1);
        checkOutput("both_empty_ovf",   32'(overflow),  32'd0);
        checkOutput("both_empty_dout",  dout,           32'h0000_00A0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b1, 32'h0000_00A0 + 32'(i), 1'b0);
        end
        checkOutput("both_full_pre", 32'(full), 32'd1);

        // Simultaneous requests while full: read taken, write dropped.
        applyStimulus(1'b1, 32'h0000_00FF, 1'b1);
        checkOutput("both_full_count", 32'(count),    32'd15);
        checkOutput("both_full_ovf",   32'(overflow), 32'd1);
        checkOutput("both_full_dout",  dout,          32'h0000_00A1);
        checkOutput("both_full_flag",  32'(full),     32'd0);

        pulseReset();

        // Steady-state streaming at count=8 across many pointer wraps.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h0000_0100 + 32'(i), 1'b0);
        end
        checkOutput("stream_count0", 32'(count), 32'd8);
        for (int k = 0; k < 100; k++) begin
            checkOutput("stream_dout", dout, 32'h0000_0100 + 32'(k));
            applyStimulus(1'b1, 32'h0000_0108 + 32'(k), 1'b1);
            checkOutput("stream_count", 32'(count), 32'd8);
        end
        checkOutput("stream_ovf", 32'(overflow),  32'd0);
        checkOutput("stream_udf", 32'(underflow), 32'd0);

        pulseReset();

        // Asynchronous reset in the middle of a cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h0000_0050 + 32'(i), 1'b0);
        end
        checkOutput("async_pre_count", 32'(count), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_empty", 32'(empty), 32'd1);
        checkOutput("async_count", 32'(count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0000_0077, 1'b0);
        checkOutput("post_rst_dout",  dout,       32'h0000_0077);
        checkOutput("post_rst_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
